// File: rtl/regfile_pkg.sv
// Shared types and constants for the MIPS register file.
// Imported by the interface, the read-port sub-module and the top.
package regfile_pkg;

    localparam int REG_NUM = 32;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

    // Whole architectural state as one packed vector so it can be handed to read ports.
    typedef reg_data_t [REG_NUM-1:0] reg_array_t;

    typedef struct packed {
        logic      we;
        reg_addr_t addr;
        reg_data_t data;
    } wr_req_t;

    // Writes aimed at register 0 never commit.
    function automatic logic is_commit(input wr_req_t w);
        return w.we && (w.addr != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Bundle of write-back, operand-fetch and debug signals of the register file.
// master drives writes/addresses, slave returns read data and the write counter.
interface regfile_if;
    import regfile_pkg::*;

    logic      we;
    reg_addr_t wAddr;
    reg_data_t wData;
    reg_addr_t rAddr1;
    reg_data_t rData1;
    reg_addr_t rAddr2;
    reg_data_t rData2;
    reg_addr_t dbgAddr;
    reg_data_t dbgData;
    reg_data_t wrCount;

    modport master (
        output we, wAddr, wData, rAddr1, rAddr2, dbgAddr,
        input  rData1, rData2, dbgData, wrCount
    );

    modport slave (
        input  we, wAddr, wData, rAddr1, rAddr2, dbgAddr,
        output rData1, rData2, dbgData, wrCount
    );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational operand read port: index mux, register-0 forcing and,
// when REGFILE_BYPASS_EN is defined, same-cycle write-to-read bypass.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic       i_rst,
    input  reg_array_t i_regs,
    input  reg_addr_t  i_addr,
`ifdef REGFILE_BYPASS_EN
    input  wr_req_t    i_wr,
`endif
    output reg_data_t  o_data
);

    reg_data_t w_array_data;

    always_comb begin
        w_array_data = '0;
        if (i_addr != ZERO_REG) begin
            w_array_data = i_regs[i_addr];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_hit;

    // The incoming write wins only if it would actually commit on this edge.
    assign w_hit = !i_rst && is_commit(i_wr) && (i_wr.addr == i_addr);

    always_comb begin
        o_data = w_array_data;
        if (i_rst) begin
            o_data = '0;
        end else if (w_hit) begin
            o_data = i_wr.data;
        end
    end
`else
    always_comb begin
        o_data = w_array_data;
        if (i_rst) begin
            o_data = '0;
        end
    end
`endif

endmodule

// File: rtl/regfile.sv
// 32x32 MIPS register file: one write port, two operand read ports, a debug
// read port and a committed-write counter. Optional bypass: REGFILE_BYPASS_EN.
module regfile
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);

    reg_array_t           r_regs;
    reg_data_t            r_wr_count;
    wr_req_t              w_wr;
    logic                 w_commit;
    logic [REG_NUM-1:0]   w_wr_sel;

    assign w_wr     = '{we: bus.we, addr: bus.wAddr, data: bus.wData};
    assign w_commit = is_commit(w_wr);

    // One-hot write decode; slot 0 is never selected so register 0 stays zero.
    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_wr_sel
            if (gi == 0) begin : g_zero
                assign w_wr_sel[gi] = 1'b0;
            end else begin : g_reg
                assign w_wr_sel[gi] = w_commit && (w_wr.addr == reg_addr_t'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs     <= '0;
            r_wr_count <= '0;
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (w_wr_sel[i]) begin
                    r_regs[i] <= w_wr.data;
                end
            end
            if (w_commit) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    regfile_read_port u_rd1 (
        .i_rst  (rst),
        .i_regs (r_regs),
        .i_addr (bus.rAddr1),
`ifdef REGFILE_BYPASS_EN
        .i_wr   (w_wr),
`endif
        .o_data (bus.rData1)
    );

    regfile_read_port u_rd2 (
        .i_rst  (rst),
        .i_regs (r_regs),
        .i_addr (bus.rAddr2),
`ifdef REGFILE_BYPASS_EN
        .i_wr   (w_wr),
`endif
        .o_data (bus.rData2)
    );

    // Debug view is committed state only, never bypassed.
    always_comb begin
        bus.dbgData = '0;
        if (!rst && bus.dbgAddr != ZERO_REG) begin
            bus.dbgData = r_regs[bus.dbgAddr];
        end
    end

    assign bus.wrCount = r_wr_count;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expected values are queued in a
// scoreboard when stimulus is applied and popped at each sampling point.
module tb_regfile;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    regfile_if bus();

    regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
            $display("vector %0d %s observed=%h expected=%h", vectors, e.tag, obs, e.val);
        end
    endtask

    // One committed write: drive at negedge, take one rising edge, drop we.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        bus.we    = 1'b1;
        bus.wAddr = a;
        bus.wData = d;
        @(posedge clk);
        @(negedge clk);
        bus.we    = 1'b0;
        #1;
    endtask

    initial begin
        bus.we = 1'b0; bus.wAddr = '0; bus.wData = '0;
        bus.rAddr1 = 5'd5; bus.rAddr2 = 5'd5; bus.dbgAddr = 5'd5;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset mid-run
        do_write(5'd5, 32'h1234);
        push_exp("pre_rst_dbg5", 32'h1234);   check(bus.dbgData);
        push_exp("pre_rst_rd1_5", 32'h1234);  check(bus.rData1);
        push_exp("pre_rst_cnt", 32'd1);       check(bus.wrCount);
        bus.we = 1'b1; bus.wAddr = 5'd6; bus.wData = 32'h5555;
        #2;
        rst = 1'b1;
        #1;
        push_exp("rst_rd1", 32'd0);  check(bus.rData1);
        push_exp("rst_rd2", 32'd0);  check(bus.rData2);
        push_exp("rst_dbg", 32'd0);  check(bus.dbgData);
        push_exp("rst_cnt", 32'd0);  check(bus.wrCount);
        @(posedge clk);
        @(negedge clk);
        bus.we = 1'b0;
        rst = 1'b0;
        #1;
        push_exp("post_rst_rd1_5", 32'd0);  check(bus.rData1);
        bus.dbgAddr = 5'd6; #1;
        push_exp("post_rst_dbg6_lost", 32'd0);  check(bus.dbgData);
        push_exp("post_rst_cnt", 32'd0);        check(bus.wrCount);

        // Basic write/read
        do_write(5'd8, 32'hDEADBEEF);
        bus.rAddr1 = 5'd8; bus.rAddr2 = 5'd8; bus.dbgAddr = 5'd8; #1;
        push_exp("basic_rd1", 32'hDEADBEEF);  check(bus.rData1);
        push_exp("basic_rd2", 32'hDEADBEEF);  check(bus.rData2);
        push_exp("basic_dbg", 32'hDEADBEEF);  check(bus.dbgData);
        push_exp("basic_cnt", 32'd1);         check(bus.wrCount);

        // Register zero: discarded write, no bypass, no count
        bus.rAddr1 = 5'd0; bus.rAddr2 = 5'd0; bus.dbgAddr = 5'd0;
        bus.we = 1'b1; bus.wAddr = 5'd0; bus.wData = 32'hFFFFFFFF; #1;
        push_exp("zero_pre_rd1", 32'd0);  check(bus.rData1);
        push_exp("zero_pre_rd2", 32'd0);  check(bus.rData2);
        @(posedge clk);
        @(negedge clk);
        bus.we = 1'b0; #1;
        push_exp("zero_rd1", 32'd0);  check(bus.rData1);
        push_exp("zero_rd2", 32'd0);  check(bus.rData2);
        push_exp("zero_dbg", 32'd0);  check(bus.dbgData);
        push_exp("zero_cnt", 32'd1);  check(bus.wrCount);

        // Bypass behaviour on port 1
        do_write(5'd3, 32'h11);
        bus.rAddr1 = 5'd3; bus.dbgAddr = 5'd3;
        bus.we = 1'b1; bus.wAddr = 5'd3; bus.wData = 32'h22; #1;
        push_exp("byp_pre_rd1", BYP ? 32'h22 : 32'h11);  check(bus.rData1);
        push_exp("byp_pre_dbg", 32'h11);                 check(bus.dbgData);
        @(posedge clk);
        @(negedge clk);
        bus.we = 1'b0; #1;
        push_exp("byp_post_rd1", 32'h22);  check(bus.rData1);
        push_exp("byp_post_dbg", 32'h22);  check(bus.dbgData);
        push_exp("byp_cnt", 32'd3);        check(bus.wrCount);

        // Dual-port independence
        do_write(5'd1, 32'hA);
        do_write(5'd2, 32'hB);
        bus.rAddr1 = 5'd2; bus.rAddr2 = 5'd1; #1;
        push_exp("dual_rd1", 32'hB);  check(bus.rData1);
        push_exp("dual_rd2", 32'hA);  check(bus.rData2);
        bus.we = 1'b1; bus.wAddr = 5'd2; bus.wData = 32'hC; #1;
        push_exp("dual_byp_rd1", BYP ? 32'hC : 32'hB);  check(bus.rData1);
        push_exp("dual_byp_rd2", 32'hA);                check(bus.rData2);
        @(posedge clk);
        @(negedge clk);
        bus.rAddr2 = 5'd2;
        bus.wData = 32'hD; #1;
        push_exp("same_tgt_rd1", BYP ? 32'hD : 32'hC);  check(bus.rData1);
        push_exp("same_tgt_rd2", BYP ? 32'hD : 32'hC);  check(bus.rData2);
        @(posedge clk);
        @(negedge clk);
        bus.we = 1'b0; #1;
        push_exp("same_tgt_post_rd2", 32'hD);  check(bus.rData2);
        push_exp("dual_cnt", 32'd7);           check(bus.wrCount);

        // Counter wrap
        force dut.r_wr_count = 32'hFFFFFFFF;
        #1;
        release dut.r_wr_count;
        #1;
        push_exp("wrap_preload", 32'hFFFFFFFF);  check(bus.wrCount);
        @(negedge clk);
        do_write(5'd4, 32'h44);
        bus.dbgAddr = 5'd4; #1;
        push_exp("wrap_cnt", 32'd0);   check(bus.wrCount);
        push_exp("wrap_dbg4", 32'h44); check(bus.dbgData);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
